// File: rtl/sr_flag_arbiter_pkg.sv
// Shared definitions for the set/reset flag arbiter: command encodings and
// the round-robin selection helper.
package sr_ctl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  // Returns {found, index}: first set bit of elig at or after ptr, wrapping at n.
  function automatic logic [4:0] rr_pick(input logic [15:0] elig,
                                         input logic [3:0]  ptr,
                                         input int          n);
    logic [4:0] res;
    int         c;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < n && !res[4]) begin
        c = (int'(ptr) + k) % n;
        if (elig[c]) res = {1'b1, 4'(c)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side bus of the flag arbiter: per-requester commands in,
// one-hot grant, flag bank state and error report out.
interface sr_flag_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = $clog2(NFLAG)
);
  logic [NREQ-1:0]         req;
  logic [2*NREQ-1:0]       op;
  logic [IDXW*NREQ-1:0]    idx;
  logic [NREQ-1:0]         gnt;
  logic [NFLAG-1:0]        flags;
  logic [NFLAG-1:0]        flags_n;
  logic                    err;
  logic [$clog2(NREQ)-1:0] err_id;

  modport master (output req, op, idx, input gnt, flags, flags_n, err, err_id);
  modport slave  (input req, op, idx, output gnt, flags, flags_n, err, err_id);
endinterface

// File: rtl/sr_flag_cell.sv
// One clocked set/reset flag with complementary outputs; set wins if both
// inputs were ever high, though the arbiter never drives them together.
module sr_flag_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end else if (s) begin
      q    <= 1'b1;
      qbar <= 1'b0;
    end else if (r) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that executes one set/clear command per cycle on a
// shared bank of SR flag cells and flags illegal or out-of-range commands.
module sr_flag_arbiter
  import sr_ctl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = $clog2(NFLAG)
) (
  input logic               clk,
  input logic               rst,
  sr_flag_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic             err_reg, err_next;
  logic [PW-1:0]    err_id_reg, err_id_next;

  logic [4:0]       pick;
  logic             win_valid;
  logic [PW-1:0]    win_idx;
  logic [1:0]       op_w;
  logic [IDXW-1:0]  idx_w;
  logic             idx_ok;
  logic [NFLAG-1:0] s_vec, r_vec;

  always_comb begin
    gnt_next    = '0;
    ptr_next    = ptr_reg;
    err_next    = 1'b0;
    err_id_next = '0;
    op_w        = OP_HOLD;
    idx_w       = '0;
    idx_ok      = 1'b0;

    // Last winner is masked so it cannot be re-granted while it drops req.
    pick      = rr_pick(16'(bus.req & ~gnt_reg), 4'(ptr_reg), NREQ);
    win_valid = pick[4];
    win_idx   = PW'(pick[3:0]);

    if (win_valid) begin
      op_w   = bus.op[2*win_idx +: 2];
      idx_w  = bus.idx[IDXW*win_idx +: IDXW];
      idx_ok = ({1'b0, idx_w} < (IDXW+1)'(NFLAG));
      gnt_next[win_idx] = 1'b1;
      ptr_next = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      if (op_w == OP_ILL || !idx_ok) begin
        err_next    = 1'b1;
        err_id_next = win_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg    <= '0;
      ptr_reg    <= '0;
      err_reg    <= 1'b0;
      err_id_reg <= '0;
    end else begin
      gnt_reg    <= gnt_next;
      ptr_reg    <= ptr_next;
      err_reg    <= err_next;
      err_id_reg <= err_id_next;
    end
  end

  // Only the addressed cell sees a strobe, and set/clear are mutually exclusive.
  genvar gi;
  generate
    for (gi = 0; gi < NFLAG; gi++) begin : g_cell
      assign s_vec[gi] = win_valid && idx_ok && (op_w == OP_SET) && (idx_w == IDXW'(gi));
      assign r_vec[gi] = win_valid && idx_ok && (op_w == OP_CLR) && (idx_w == IDXW'(gi));

      sr_flag_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .s    (s_vec[gi]),
        .r    (r_vec[gi]),
        .q    (bus.flags[gi]),
        .qbar (bus.flags_n[gi])
      );
    end
  endgenerate

  assign bus.gnt    = gnt_reg;
  assign bus.err    = err_reg;
  assign bus.err_id = err_id_reg;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: walks reset, single commands, round
// robin, error reporting, same-flag serialisation and reset-drop behaviour.
module tb_sr_flag_arbiter;
  import sr_ctl_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sr_flag_arbiter_if #(.NREQ(4), .NFLAG(8)) bus ();

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic post(input int i, input logic [1:0] o, input logic [2:0] ix);
    bus.req[i]        = 1'b1;
    bus.op[2*i +: 2]  = o;
    bus.idx[3*i +: 3] = ix;
  endtask

  task automatic drop(input int i);
    bus.req[i] = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    bus.op  = '0;
    bus.idx = '0;

    // 1: reset and idle
    tick(); tick();
    chk("rst_flags",   32'(bus.flags),   32'h00);
    chk("rst_flags_n", 32'(bus.flags_n), 32'hFF);
    chk("rst_gnt",     32'(bus.gnt),     32'h0);
    chk("rst_err",     32'(bus.err),     32'h0);
    chk("rst_err_id",  32'(bus.err_id),  32'h0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_gnt",    32'(bus.gnt),     32'h0);
    chk("idle_flags",  32'(bus.flags),   32'h00);
    chk("idle_err",    32'(bus.err),     32'h0);

    // 2: requester 2 sets then clears flag 5
    post(2, OP_SET, 3'd5);
    tick();
    chk("t2_gnt",      32'(bus.gnt),     32'h4);
    chk("t2_flags",    32'(bus.flags),   32'h20);
    chk("t2_flags_n",  32'(bus.flags_n), 32'hDF);
    drop(2);
    tick();
    chk("t2_gnt_off",  32'(bus.gnt),     32'h0);
    post(2, OP_CLR, 3'd5);
    tick();
    chk("t2_gnt_clr",  32'(bus.gnt),     32'h4);
    chk("t2_flags_c",  32'(bus.flags),   32'h00);
    drop(2);
    tick();

    // 3: all four set distinct flags; pointer restarted at 0 by reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) post(i, OP_SET, 3'(i));
    tick(); chk("t3_g0",      32'(bus.gnt),   32'h1);
    tick(); chk("t3_g1",      32'(bus.gnt),   32'h2);
    tick(); chk("t3_g2",      32'(bus.gnt),   32'h4);
    tick(); chk("t3_g3",      32'(bus.gnt),   32'h8);
    chk("t3_flags",   32'(bus.flags),   32'h0F);
    tick(); chk("t3_g0b",     32'(bus.gnt),   32'h1);
    for (int i = 0; i < 4; i++) drop(i);
    tick(); chk("t3_idle",    32'(bus.gnt),   32'h0);

    // 4: illegal op from requester 1, then a hold from requester 0
    post(1, OP_ILL, 3'd3);
    tick();
    chk("t4_gnt",      32'(bus.gnt),     32'h2);
    chk("t4_err",      32'(bus.err),     32'h1);
    chk("t4_err_id",   32'(bus.err_id),  32'h1);
    chk("t4_flags",    32'(bus.flags),   32'h0F);
    drop(1);
    post(0, OP_HOLD, 3'd0);
    tick();
    chk("t4_hold_gnt", 32'(bus.gnt),     32'h1);
    chk("t4_hold_err", 32'(bus.err),     32'h0);
    chk("t4_hold_flg", 32'(bus.flags),   32'h0F);
    drop(0);
    tick();
    chk("t4_err_off",  32'(bus.err),     32'h0);

    // 5: move pointer to 3 with a hold from 2, then 0 and 3 collide on flag 7
    post(2, OP_HOLD, 3'd0);
    tick();
    chk("t5_pre_gnt",  32'(bus.gnt),     32'h4);
    drop(2);
    tick();
    post(0, OP_SET, 3'd7);
    post(3, OP_CLR, 3'd7);
    tick();
    chk("t5_gnt3",     32'(bus.gnt),     32'h8);
    chk("t5_flags3",   32'(bus.flags),   32'h0F);
    drop(3);
    tick();
    chk("t5_gnt0",     32'(bus.gnt),     32'h1);
    chk("t5_flags0",   32'(bus.flags),   32'h8F);
    drop(0);
    tick();
    chk("t5_idle",     32'(bus.gnt),     32'h0);

    // 6: request arriving together with reset is dropped, then re-granted
    post(2, OP_SET, 3'd6);
    rst = 1'b1;
    tick();
    chk("t6_rst_gnt",  32'(bus.gnt),     32'h0);
    chk("t6_rst_flg",  32'(bus.flags),   32'h00);
    rst = 1'b0;
    tick();
    chk("t6_gnt",      32'(bus.gnt),     32'h4);
    chk("t6_flags",    32'(bus.flags),   32'h40);
    chk("t6_flags_n",  32'(bus.flags_n), 32'hBF);
    drop(2);
    tick();
    chk("t6_idle",     32'(bus.gnt),     32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
